rd_capture_buffer: RTL and testbench
====================================

Name: rd_capture_buffer

Overview:
- Downstream consumer of the memory read-control FSM.
- Samples the read data bus on every accepted read beat (rd high, ws low).
- Frames the beats of one transaction using the ds done pulse, and buffers them in a small FIFO.
- Presents buffered words to the next stage over a valid/ready stream with a last flag, and reports the length of each completed transaction.

Parameters:
- DW, 8, read data width.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- LW, 8, transaction length counter width.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd  in  1  read strobe from the read-control FSM.
- ws  in  1  wait-state; a beat is accepted only when rd=1 and ws=0.
- ds  in  1  done pulse; closes the current transaction.
- din  in  DW  read data bus.
- clr  in  1  synchronous clear of the sticky error flags only.
- m_valid  out  1  output word available.
- m_ready  in  1  downstream accepts the word.
- m_data  out  DW  output word.
- m_last  out  1  word is the final beat of its transaction.
- len_valid  out  1  one-cycle pulse: txn_len updated.
- txn_len  out  LW  beat count of the last completed transaction.
- ovf  out  1  sticky: a word was dropped because the FIFO was full.
- perr  out  1  sticky: protocol error, rd and ds high in the same cycle.

Behaviour:
- Reset (rst=1 at an edge, including mid-transaction):
  - Clears the staging register, FIFO pointers, beat counter, ovf and perr.
  - Outputs m_valid=0, m_last=0, len_valid=0, txn_len=0, m_data=0.
  - Any partial transaction is discarded.
- beat = rd & ~ws & ~ds.
- Staging FSM (one-word look-ahead, needed to tag the last beat):
  - States: EMPTY, HOLD.
  - EMPTY + beat: load din into the staging register; go to HOLD.
  - HOLD + beat: push the staged word with last=0; load din; stay in HOLD.
  - HOLD + ds: push the staged word with last=1; go to EMPTY.
  - EMPTY + ds: zero-beat transaction; no push; txn_len updates to 0.
  - Otherwise: hold state.
- Transaction length:
  - The beat counter increments on each beat and saturates at 2^LW-1.
  - On ds: txn_len <= counter value including that cycle's count, len_valid=1 next cycle, counter <= 0.
- rd=1 and ds=1 together (illegal): ds and the beat are both ignored that cycle; perr set.
- FIFO:
  - push_ok = push & (~full | pop); pop = m_valid & m_ready.
  - Simultaneous push and pop are allowed when full or empty; when empty, the pushed word appears the next cycle (no fall-through).
  - A push refused because the FIFO is full drops that word (including a last-tagged word) and sets ovf.
  - The staging FSM advances regardless of a refused push.
- Latency: a word captured at cycle N is pushed no earlier than cycle N+1 (next beat or ds); m_valid rises on the cycle after the push.
- Sticky flags: ovf and perr clear only on rst or clr. If clr coincides with a new error event, the flag remains set.
- Pointers: log2(DEPTH)+1 bits, wrap naturally. Full when the MSBs differ and the remaining bits are equal.
- m_data and m_last are registered FIFO read outputs, stable while m_valid=1 and m_ready=0.

Decomposition:
- Shared package rd_cap_pkg holds:
  - staging state encoding (ST_EMPTY=1'b0, ST_HOLD=1'b1);
  - default DW, DEPTH, LW constants;
  - the FIFO entry layout {last, data}, DW+1 bits.
- One sub-module, sync_fifo:
  - Parameterised width DW+1 and depth.
  - Ports: clk, rst, push, pop, wdata, rdata, full, empty.
  - Instantiated once; the staging FSM, counter and flags stay in the top.

Test Plan:
- 3-beat read, m_ready=1: din=0x11,0x22,0x33 on beats, ds 1 cycle after the last beat -> outputs 0x11/last0, 0x22/last0, 0x33/last1; len_valid pulse with txn_len=3.
- Wait states: rd=1 with ws=1 for 2 cycles between beats 0xA0 and 0xA1, then ds -> only 2 words out, 0xA1 has last=1, txn_len=2; no capture during ws cycles.
- Overflow, DEPTH=8, m_ready=0: a 10-beat transaction plus ds -> FIFO holds beats 1-8, ovf=1. Draining yields 8 words, none with last=1; clr then drops ovf to 0.
- Zero-beat transaction: ds with no preceding beat -> no output word; len_valid pulse with txn_len=0.
- Protocol error and reset: rd=1 and ds=1 in the same cycle -> perr=1, no push, no length update. Then rst asserted mid-transaction after 2 beats -> m_valid=0, perr=0, next 1-beat transaction outputs a single word with last=1 and txn_len=1.
- Backpressure: toggle m_ready 1/0 every cycle during a 4-beat transaction 0x01-0x04 -> words delivered in order, m_data stable while stalled, exactly one last=1 on 0x04.

Source files
------------

// File: rtl/rd_cap_pkg.sv
// rtl/rd_cap_pkg.sv - shared types and defaults for the read capture buffer
package rd_cap_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 8;
  localparam int LW_DEF    = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } stage_state_t;

  // FIFO entry layout at default width: {last, data}
  typedef struct packed {
    logic              last;
    logic [DW_DEF-1:0] data;
  } fifo_entry_t;

  function automatic int entry_width(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/rd_capture_buffer_if.sv
// rtl/rd_capture_buffer_if.sv - read bus input and output word stream bundle
interface rd_capture_buffer_if
  import rd_cap_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic          rd;
  logic          ws;
  logic          ds;
  logic [DW-1:0] din;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (
    output rd, ws, ds, din, m_ready,
    input  m_valid, m_data, m_last
  );

  modport slave (
    input  rd, ws, ds, din, m_ready,
    output m_valid, m_data, m_last
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with wrap-bit pointers, no fall-through
module sync_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage is registered; gate to zero when empty so reset shows clean data
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/rd_capture_buffer.sv
// rtl/rd_capture_buffer.sv - frames read beats into transactions and streams them out
module rd_capture_buffer
  import rd_cap_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LW    = LW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  rd_capture_buffer_if.slave   bus,
  input  logic                 clr,
  output logic                 len_valid,
  output logic [LW-1:0]        txn_len,
  output logic                 ovf,
  output logic                 perr
);

  localparam int EW = entry_width(DW);

  stage_state_t  state;
  stage_state_t  state_nx;
  logic [DW-1:0] stage_q;
  logic [LW-1:0] cnt;
  logic          beat;
  logic          ds_ok;
  logic          proto_err;
  logic          load;
  logic          push;
  logic          push_last;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic          empty;
  logic [EW-1:0] rdata;

  // rd together with ds is illegal: both the beat and the done are ignored
  assign beat      = bus.rd & ~bus.ws & ~bus.ds;
  assign ds_ok     = bus.ds & ~bus.rd;
  assign proto_err = bus.rd & bus.ds;

  assign pop     = bus.m_valid & bus.m_ready;
  assign push_ok = push & (~full | pop);

  assign bus.m_valid             = ~empty;
  assign {bus.m_last, bus.m_data} = rdata;

  // One-word look-ahead: a word is only pushed once we know whether it is last
  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    push      = 1'b0;
    push_last = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (beat) begin
          load     = 1'b1;
          state_nx = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (beat) begin
          push = 1'b1;
          load = 1'b1;
        end else if (ds_ok) begin
          push      = 1'b1;
          push_last = 1'b1;
          state_nx  = ST_EMPTY;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      stage_q   <= '0;
      cnt       <= '0;
      txn_len   <= '0;
      len_valid <= 1'b0;
      ovf       <= 1'b0;
      perr      <= 1'b0;
    end else begin
      state     <= state_nx;
      len_valid <= ds_ok;
      if (load) stage_q <= bus.din;
      if (ds_ok) begin
        txn_len <= cnt;
        cnt     <= '0;
      end else if (beat && (cnt != {LW{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
      ovf  <= (ovf & ~clr) | (push & ~push_ok);
      perr <= (perr & ~clr) | proto_err;
    end
  end

  sync_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .wdata ({push_last, stage_q}),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_rd_capture_buffer.sv
// tb/tb_rd_capture_buffer.sv - directed self-checking bench for rd_capture_buffer
module tb_rd_capture_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       len_valid;
  logic [7:0] txn_len;
  logic       ovf;
  logic       perr;
  logic       toggle_ready = 1'b0;

  int ncmp  = 0;
  int nfail = 0;

  logic [7:0] got_data [$];
  logic       got_last [$];
  logic [7:0] len_q    [$];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  logic       prev_last  = 1'b0;

  rd_capture_buffer_if #(.DW(8)) bus ();

  rd_capture_buffer #(.DW(8), .DEPTH(8), .LW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clr       (clr),
    .len_valid (len_valid),
    .txn_len   (txn_len),
    .ovf       (ovf),
    .perr      (perr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (toggle_ready) bus.m_ready = ~bus.m_ready;
  endtask

  task automatic idle(input int n);
    bus.rd = 1'b0;
    bus.ws = 1'b0;
    bus.ds = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic beat(input logic [7:0] d);
    bus.rd  = 1'b1;
    bus.ws  = 1'b0;
    bus.ds  = 1'b0;
    bus.din = d;
    cyc();
  endtask

  task automatic done();
    bus.rd = 1'b0;
    bus.ws = 1'b0;
    bus.ds = 1'b1;
    cyc();
    bus.ds = 1'b0;
  endtask

  task automatic clear_q();
    got_data.delete();
    got_last.delete();
    len_q.delete();
  endtask

  function automatic logic [7:0] data_at(input int i);
    return (i < got_data.size()) ? got_data[i] : 8'hxx;
  endfunction

  function automatic logic last_at(input int i);
    return (i < got_last.size()) ? got_last[i] : 1'bx;
  endfunction

  function automatic logic [7:0] len_at(input int i);
    return (i < len_q.size()) ? len_q[i] : 8'hxx;
  endfunction

  // Record accepted words and length pulses; data must hold steady while stalled
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && bus.m_valid) begin
        check("stall_data", bus.m_data, prev_data);
        check("stall_last", bus.m_last, prev_last);
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      if (bus.m_valid && bus.m_ready) begin
        got_data.push_back(bus.m_data);
        got_last.push_back(bus.m_last);
      end
      if (len_valid) len_q.push_back(txn_len);
    end
  end

  initial begin
    logic [7:0] exp_d [4];
    int         nlast;

    bus.rd      = 1'b0;
    bus.ws      = 1'b0;
    bus.ds      = 1'b0;
    bus.din     = 8'h00;
    bus.m_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    check("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_m_last", bus.m_last, 1'b0);
    check("rst_m_data", bus.m_data, 8'h00);
    check("rst_len_valid", len_valid, 1'b0);
    check("rst_txn_len", txn_len, 8'h00);
    check("rst_ovf", ovf, 1'b0);
    check("rst_perr", perr, 1'b0);

    // 3-beat transaction with open sink
    clear_q();
    beat(8'h11);
    check("t1_staged_only", bus.m_valid, 1'b0);
    beat(8'h22);
    check("t1_first_valid", bus.m_valid, 1'b1);
    check("t1_first_data", bus.m_data, 8'h11);
    beat(8'h33);
    done();
    check("t1_len_pulse", len_valid, 1'b1);
    check("t1_len_val", txn_len, 8'd3);
    cyc();
    check("t1_len_drop", len_valid, 1'b0);
    idle(3);
    check("t1_count", got_data.size(), 3);
    check("t1_d0", data_at(0), 8'h11);
    check("t1_l0", last_at(0), 1'b0);
    check("t1_d1", data_at(1), 8'h22);
    check("t1_l1", last_at(1), 1'b0);
    check("t1_d2", data_at(2), 8'h33);
    check("t1_l2", last_at(2), 1'b1);
    check("t1_len_count", len_q.size(), 1);

    // Wait states between two beats
    clear_q();
    beat(8'hA0);
    bus.rd  = 1'b1;
    bus.ws  = 1'b1;
    bus.din = 8'hEE;
    cyc();
    bus.din = 8'hEF;
    cyc();
    beat(8'hA1);
    done();
    idle(3);
    check("t2_count", got_data.size(), 2);
    check("t2_d0", data_at(0), 8'hA0);
    check("t2_l0", last_at(0), 1'b0);
    check("t2_d1", data_at(1), 8'hA1);
    check("t2_l1", last_at(1), 1'b1);
    check("t2_len", len_at(0), 8'd2);

    // Overflow: 10 beats into an 8-deep FIFO with the sink stalled
    clear_q();
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 10; i++) beat(8'(i));
    done();
    idle(2);
    check("t3_ovf_set", ovf, 1'b1);
    check("t3_valid_full", bus.m_valid, 1'b1);
    check("t3_len", len_at(0), 8'd10);
    bus.m_ready = 1'b1;
    idle(12);
    check("t3_count", got_data.size(), 8);
    nlast = 0;
    for (int i = 0; i < 8; i++) begin
      check("t3_data", data_at(i), 8'(i + 1));
      if (last_at(i) === 1'b1) nlast++;
    end
    check("t3_no_last", nlast, 0);
    check("t3_ovf_sticky", ovf, 1'b1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("t3_ovf_clr", ovf, 1'b0);

    // Zero-beat transaction
    clear_q();
    done();
    idle(3);
    check("t4_no_word", got_data.size(), 0);
    check("t4_len_count", len_q.size(), 1);
    check("t4_len", len_at(0), 8'd0);

    // rd with ds is a protocol error: nothing pushed, no length update
    clear_q();
    bus.rd  = 1'b1;
    bus.ds  = 1'b1;
    bus.din = 8'h55;
    cyc();
    bus.rd  = 1'b0;
    bus.ds  = 1'b0;
    check("t5_perr", perr, 1'b1);
    idle(3);
    check("t5_no_word", got_data.size(), 0);
    check("t5_no_len", len_q.size(), 0);
    check("t5_perr_sticky", perr, 1'b1);

    // Reset mid-transaction discards partial data
    bus.m_ready = 1'b0;
    beat(8'h77);
    beat(8'h88);
    check("t5_pre_rst_valid", bus.m_valid, 1'b1);
    bus.rd = 1'b0;
    rst    = 1'b1;
    cyc();
    rst    = 1'b0;
    check("t5_rst_valid", bus.m_valid, 1'b0);
    check("t5_rst_perr", perr, 1'b0);
    check("t5_rst_data", bus.m_data, 8'h00);
    bus.m_ready = 1'b1;
    clear_q();
    beat(8'h99);
    done();
    idle(3);
    check("t5_count", got_data.size(), 1);
    check("t5_d0", data_at(0), 8'h99);
    check("t5_l0", last_at(0), 1'b1);
    check("t5_len", len_at(0), 8'd1);

    // Backpressure: m_ready toggles every cycle
    clear_q();
    exp_d[0] = 8'h01;
    exp_d[1] = 8'h02;
    exp_d[2] = 8'h03;
    exp_d[3] = 8'h04;
    toggle_ready = 1'b1;
    for (int i = 0; i < 4; i++) beat(exp_d[i]);
    done();
    idle(10);
    toggle_ready = 1'b0;
    bus.m_ready  = 1'b1;
    idle(2);
    check("t6_count", got_data.size(), 4);
    nlast = 0;
    for (int i = 0; i < 4; i++) begin
      check("t6_data", data_at(i), exp_d[i]);
      if (last_at(i) === 1'b1) nlast++;
    end
    check("t6_one_last", nlast, 1);
    check("t6_last_on_04", last_at(3), 1'b1);
    check("t6_len", len_at(0), 8'd4);
    check("t6_no_ovf", ovf, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
